// File: rtl/uart_frame_rx_pkg.sv
// Shared types and constants for the UART frame receiver.
// Holds state encodings, abort cause codes and the default sync marker.
package uart_frame_rx_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_FRAMING  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    P_HUNT,
    P_LOAD,
    P_CHECK
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, mid-bit sampling, stop check.
// Emits one-cycle byte_valid or framing_err pulses.
module uart_rx_byte
  import uart_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  logic          r_meta;
  logic          r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_half;
  logic          w_full;

  assign w_half = (r_cnt == HALF_M1);
  assign w_full = (r_cnt == FULL_M1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= RX_IDLE;
      r_meta      <= 1'b1;
      r_sync      <= 1'b1;
      r_prev      <= 1'b1;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      r_meta      <= RX;
      r_sync      <= r_meta;
      r_prev      <= r_sync;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      unique case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (r_prev && !r_sync) r_state <= RX_START;
        end
        RX_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            // a start bit that is high again at mid-bit was a glitch
            r_state <= r_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {r_sync, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= r_shift;
            end else begin
              framing_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser over uart_rx_byte: SYNC + payload + checksum into a
// double-buffered column store read by the display sequencer.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int         CLK_HZ       = 12_000_000,
  parameter int         BAUD         = 115_200,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
  parameter int         FRAME_LEN    = 16,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RX,
  input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
  output logic [7:0]                   rd_data,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic [1:0]                   err_code,
  output logic                         busy
);

  localparam int AW     = $clog2(FRAME_LEN);
  localparam int AW1    = AW + 1;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int TO_LIM = TIMEOUT_BITS * CPB;
  localparam int TW     = $clog2(TO_LIM + 1);
  localparam logic [AW-1:0] LAST   = AW'(FRAME_LEN - 1);
  localparam logic [AW:0]   LEN    = AW1'(FRAME_LEN);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIM);

  logic [7:0]    w_byte;
  logic          w_byte_valid;
  logic          w_ferr;
  logic          w_timeout;
  logic          w_in_range;

  parse_state_t  r_state;
  logic          r_active;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_bank [2][FRAME_LEN];

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .RX         (RX),
    .byte_data  (w_byte),
    .byte_valid (w_byte_valid),
    .framing_err(w_ferr)
  );

  assign w_timeout  = (r_tcnt == TO_MAX);
  assign w_in_range = ({1'b0, rd_addr} < LEN);
  assign busy       = (r_state != P_HUNT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= P_HUNT;
      r_active   <= 1'b0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_tcnt     <= '0;
      rd_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < FRAME_LEN; i++)
          r_bank[b][i] <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      rd_data    <= w_in_range ? r_bank[r_active][rd_addr] : 8'h00;

      if (busy && !w_byte_valid) r_tcnt <= r_tcnt + 1'b1;
      else                       r_tcnt <= '0;

      unique case (r_state)
        P_HUNT: begin
          if (w_byte_valid && w_byte == SYNC_BYTE) begin
            r_state <= P_LOAD;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        P_LOAD, P_CHECK: begin
          // a completed byte outranks a same-cycle timeout
          if (w_byte_valid) begin
            if (r_state == P_LOAD) begin
              r_bank[~r_active][r_idx] <= w_byte;
              r_sum <= r_sum + w_byte;
              r_idx <= r_idx + 1'b1;
              if (r_idx == LAST) r_state <= P_CHECK;
            end else begin
              r_state <= P_HUNT;
              if (w_byte == r_sum) begin
                r_active   <= ~r_active;
                frame_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHECKSUM;
              end
            end
          end else if (w_ferr) begin
            r_state   <= P_HUNT;
            frame_err <= 1'b1;
            err_code  <= ERR_FRAMING;
          end else if (w_timeout) begin
            r_state   <= P_HUNT;
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
        end
        default: r_state <= P_HUNT;
      endcase
    end
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- UART receiver and frame loader upstream of the LED-array display sequencer.
- Receives 8N1 serial bytes on RX and parses frames of SYNC + FRAME_LEN pixel bytes + checksum.
- Holds the frame in a double-buffered register file that the sequencer reads by column index, replacing the hard-coded column table.
- Signals a completed frame with frame_done, so the sequencer can trigger a refresh instead of waiting for its 1 Hz tick.

Parameters:
- CLK_HZ, 12_000_000, input clock frequency.
- BAUD, 115_200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, 104 at defaults).
- SYNC_BYTE, 8'hA5, frame start marker.
- FRAME_LEN, 16, pixel bytes per frame (one per display column).
- TIMEOUT_BITS, 20, maximum idle gap in bit times between bytes inside a frame.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- RX  in  1  asynchronous serial input, idle high
- rd_addr  in  $clog2(FRAME_LEN)  column index from the display sequencer
- rd_data  out  8  pixel byte of the active bank at rd_addr, registered
- frame_done  out  1  one-cycle pulse when a valid frame becomes active
- frame_err  out  1  one-cycle pulse on a frame abort
- err_code  out  2  cause of the last abort: 1 framing, 2 checksum, 3 timeout; holds until the next abort
- busy  out  1  high while a frame is partially received (LOAD or CHECK state)

Behaviour:
- Reset: rd_data, frame_done, frame_err, err_code, busy = 0; both banks cleared to 8'h00; active bank = 0; parser in HUNT; byte receiver idle. Reset asserted mid-frame discards all partial data.
- RX passes through a 2-FF synchronizer, preset to 1 by reset. Everything below uses the synchronized signal.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized 1→0 transition.
  - START: re-sample at CLKS_PER_BIT/2. If low, go to DATA. If high, it is a false start: return to IDLE with no error.
  - DATA: 8 samples at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample once. High gives byte_valid for one cycle. Low gives framing_err for one cycle and no byte_valid.
  - Back to IDLE the cycle after the stop sample.
- Parser states: HUNT, LOAD, CHECK.
  - HUNT: a byte equal to SYNC_BYTE → LOAD, with index = 0 and sum = 0. Any other byte is ignored silently.
  - LOAD: each byte is written to the shadow bank at index, sum += byte (mod 256), index += 1. When index reaches FRAME_LEN-1, → CHECK. A SYNC_BYTE value inside the payload is ordinary data.
  - CHECK: if byte == sum, swap banks (active ← shadow), pulse frame_done, → HUNT. Otherwise pulse frame_err with err_code = 2, → HUNT; the active bank is unchanged.
- A framing error in LOAD or CHECK aborts the frame: frame_err pulse, err_code = 1, → HUNT. A framing error in HUNT is ignored.
- Timeout counter:
  - Runs in LOAD/CHECK and is cleared on every byte_valid.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT aborts the frame with err_code = 3.
  - If a byte completes in the same cycle as the timeout, the byte wins.
- busy = 1 exactly while the parser is in LOAD or CHECK.
- Bank swap takes effect in the frame_done cycle. rd_data has 1-cycle latency: it shows the new bank for addresses presented in the frame_done cycle or later.
- rd_addr >= FRAME_LEN returns 8'h00.
- frame_done and frame_err are never asserted in the same cycle.

Decomposition:
- Shared package holds: the err_code encodings, parser state enum, byte-receiver state enum, and default SYNC_BYTE.
- One sub-module, uart_rx_byte: synchronizer plus bit timing, with outputs byte_data, byte_valid, framing_err.
- Parser, bank registers and timeout counter stay in uart_frame_rx.

Test Plan:
- Send A5, bytes 01..10, then checksum 88 at 115200 baud → one frame_done pulse; rd_addr 0 gives 01 and rd_addr 15 gives 10 one cycle later; busy drops in the same cycle.
- Same frame with checksum 00 → frame_err with err_code = 2; rd_data still reads 00 (or the previous frame's data).
- Send 3 garbage bytes, then a valid frame containing A5 as payload byte 4 → frame accepted, rd_addr 4 reads A5, no errors.
- A5 plus 5 bytes, then idle for 25 bit times → frame_err with err_code = 3, busy = 0; a following valid frame is accepted.
- A byte with its stop bit forced low mid-LOAD → err_code = 1, parser returns to HUNT; a 30-cycle low glitch on idle RX produces no byte and no error.
- Assert RST mid-LOAD, then send a valid frame → outputs reset, then the frame loads normally; reads beforehand return 00.
